// File: rtl/multicycle_rv_core.sv
// Multi-cycle RV32I-subset core sharing one valid/ready port for instruction fetch and data access.
// Illegal encodings and misaligned addresses or targets trap to a halt state that only reset leaves.
module multicycle_rv_core #(
  parameter int unsigned NREGS    = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ready,
  output logic             halted,
  output logic [CNT_W-1:0] instret
);
  localparam int unsigned AW = $clog2(NREGS);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    ST_RST, ST_FETCH, ST_DECODE, ST_EXEC_R, ST_EXEC_I, ST_MEMADDR,
    ST_MEMREAD, ST_MEMWRITE, ST_BRANCH, ST_JAL, ST_WB, ST_TRAP
  } state_t;

  state_t           state_q, state_d, dec_next;
  logic [31:0]      pc_q, pc_d, ir_q, ir_d;
  logic [31:0]      a_q, a_d, b_q, b_d, imm_q, imm_d, res_q, res_d;
  logic             mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic [31:0]      regs_q [NREGS];

  logic             rf_we;
  logic [AW-1:0]    rf_waddr;
  logic [31:0]      rf_wdata;
  logic             go_fetch, go_trap, retire, dec_ok, taken, lt;
  logic [31:0]      pc_next, ea, tgt, diff, rs1_val, rs2_val;
  logic [31:0]      imm_i, imm_s, imm_b, imm_j;

  logic [6:0] opcode, funct7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;
  logic       rd_ok, rs1_ok, rs2_ok;

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign funct3 = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign funct7 = ir_q[31:25];

  assign rd_ok  = 32'(rd)  < NREGS;
  assign rs1_ok = 32'(rs1) < NREGS;
  assign rs2_ok = 32'(rs2) < NREGS;

  assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign halted    = halted_q;
  assign instret   = instret_q;

  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1 != '0 && rs1_ok) rs1_val = regs_q[rs1[AW-1:0]];
    if (rs2 != '0 && rs2_ok) rs2_val = regs_q[rs2[AW-1:0]];
  end

  function automatic logic [31:0] alu(input logic [31:0] x, input logic [31:0] y,
                                      input logic [2:0] f3, input logic sub);
    case (f3)
      3'b000:  alu = sub ? x - y : x + y;
      3'b111:  alu = x & y;
      3'b110:  alu = x | y;
      3'b010:  alu = {31'b0, $signed(x) < $signed(y)};
      default: alu = '0;
    endcase
  endfunction

  // Signed less-than from the subtract: sign of the difference unless the operand signs differ.
  assign ea   = a_q + imm_q;
  assign tgt  = pc_q + imm_q;
  assign diff = a_q - b_q;
  assign lt   = (a_q[31] != b_q[31]) ? a_q[31] : diff[31];

  always_comb begin
    case (funct3)
      3'b000:  taken = (diff == '0);
      3'b001:  taken = (diff != '0);
      3'b100:  taken = lt;
      3'b101:  taken = !lt;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    a_d         = a_q;
    b_d         = b_q;
    imm_d       = imm_q;
    res_d       = res_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    halted_d    = halted_q;
    instret_d   = instret_q;
    rf_we       = 1'b0;
    rf_waddr    = rd[AW-1:0];
    rf_wdata    = '0;
    go_fetch    = 1'b0;
    go_trap     = 1'b0;
    retire      = 1'b0;
    pc_next     = pc_q;
    dec_ok      = 1'b0;
    dec_next    = ST_TRAP;

    case (state_q)
      ST_RST: go_fetch = 1'b1;
      ST_FETCH: begin
        if (mem_ready) begin
          ir_d      = mem_rdata;
          mem_req_d = 1'b0;
          state_d   = ST_DECODE;
        end
      end
      ST_DECODE: begin
        a_d = rs1_val;
        b_d = rs2_val;
        case (opcode)
          OP_R: begin
            dec_next = ST_EXEC_R;
            dec_ok   = rs1_ok && rs2_ok && rd_ok &&
                       ((funct7 == 7'h00 && (funct3 inside {3'b000, 3'b111, 3'b110, 3'b010})) ||
                        (funct7 == 7'h20 && funct3 == 3'b000));
          end
          OP_I: begin
            imm_d    = imm_i;
            dec_next = ST_EXEC_I;
            dec_ok   = rs1_ok && rd_ok && (funct3 inside {3'b000, 3'b111, 3'b110, 3'b010});
          end
          OP_LW: begin
            imm_d    = imm_i;
            dec_next = ST_MEMADDR;
            dec_ok   = rs1_ok && rd_ok && funct3 == 3'b010;
          end
          OP_SW: begin
            imm_d    = imm_s;
            dec_next = ST_MEMADDR;
            dec_ok   = rs1_ok && rs2_ok && funct3 == 3'b010;
          end
          OP_BR: begin
            imm_d    = imm_b;
            dec_next = ST_BRANCH;
            dec_ok   = rs1_ok && rs2_ok && (funct3 inside {3'b000, 3'b001, 3'b100, 3'b101});
          end
          OP_JAL: begin
            imm_d    = imm_j;
            dec_next = ST_JAL;
            dec_ok   = rd_ok;
          end
          default: dec_ok = 1'b0;
        endcase
        if (dec_ok) state_d = dec_next;
        else        go_trap = 1'b1;
      end
      ST_EXEC_R: begin
        res_d   = alu(a_q, b_q, funct3, funct7[5]);
        state_d = ST_WB;
      end
      ST_EXEC_I: begin
        res_d   = alu(a_q, imm_q, funct3, 1'b0);
        state_d = ST_WB;
      end
      ST_MEMADDR: begin
        if (ea[1:0] != 2'b00) begin
          go_trap = 1'b1;
        end else begin
          mem_req_d   = 1'b1;
          mem_we_d    = (opcode == OP_SW);
          mem_addr_d  = ea;
          mem_wdata_d = b_q;
          state_d     = (opcode == OP_SW) ? ST_MEMWRITE : ST_MEMREAD;
        end
      end
      ST_MEMREAD: begin
        if (mem_ready) begin
          res_d     = mem_rdata;
          mem_req_d = 1'b0;
          state_d   = ST_WB;
        end
      end
      ST_MEMWRITE: begin
        // Store retires straight into the next fetch, so its request follows without a gap.
        if (mem_ready) begin
          pc_next  = pc_q + 32'd4;
          retire   = 1'b1;
          go_fetch = 1'b1;
        end
      end
      ST_BRANCH: begin
        if (!taken) begin
          pc_next  = pc_q + 32'd4;
          retire   = 1'b1;
          go_fetch = 1'b1;
        end else if (tgt[1:0] != 2'b00) begin
          go_trap = 1'b1;
        end else begin
          pc_next  = tgt;
          retire   = 1'b1;
          go_fetch = 1'b1;
        end
      end
      ST_JAL: begin
        if (tgt[1:0] != 2'b00) begin
          go_trap = 1'b1;
        end else begin
          rf_we    = (rd != '0);
          rf_wdata = pc_q + 32'd4;
          pc_next  = tgt;
          retire   = 1'b1;
          go_fetch = 1'b1;
        end
      end
      ST_WB: begin
        rf_we    = (rd != '0);
        rf_wdata = res_q;
        pc_next  = pc_q + 32'd4;
        retire   = 1'b1;
        go_fetch = 1'b1;
      end
      ST_TRAP: begin
        halted_d  = 1'b1;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
      default: go_trap = 1'b1;
    endcase

    if (go_trap) begin
      state_d   = ST_TRAP;
      halted_d  = 1'b1;
      mem_req_d = 1'b0;
      mem_we_d  = 1'b0;
    end else if (go_fetch) begin
      state_d    = ST_FETCH;
      pc_d       = pc_next;
      mem_req_d  = 1'b1;
      mem_we_d   = 1'b0;
      mem_addr_d = pc_next;
    end
    if (retire) instret_d = instret_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RST;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      imm_q       <= '0;
      res_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      halted_q    <= 1'b0;
      instret_q   <= '0;
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      a_q         <= a_d;
      b_q         <= b_d;
      imm_q       <= imm_d;
      res_q       <= res_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      halted_q    <= halted_d;
      instret_q   <= instret_d;
      if (rf_we) regs_q[rf_waddr] <= rf_wdata;
    end
  end
endmodule

// File: tb/tb_multicycle_rv_core.sv
// Directed bench for multicycle_rv_core: a behavioural memory slave with optional wait states
// runs small hand-assembled programs; results are observed through stores and fetch addresses.
module tb_multicycle_rv_core;
  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req, mem_we, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;
  logic [31:0] instret;

  logic        mem_req16, mem_we16, halted16, mem_ready16;
  logic [31:0] mem_addr16, mem_wdata16, mem_rdata16, instret16;

  always #5 clk = ~clk;

  multicycle_rv_core #(.NREGS(32), .RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .halted(halted), .instret(instret)
  );

  multicycle_rv_core #(.NREGS(16), .RESET_PC(32'h0000_0000), .CNT_W(32)) dut16 (
    .clk(clk), .reset(reset), .mem_req(mem_req16), .mem_we(mem_we16), .mem_addr(mem_addr16),
    .mem_wdata(mem_wdata16), .mem_rdata(mem_rdata16), .mem_ready(mem_ready16),
    .halted(halted16), .instret(instret16)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] mem [64];
  logic [31:0] p16 [4];
  logic [31:0] rlog [$];
  int          nwrites;
  bit          stall_mode, hold_ready, pend, done;
  int          wl;
  logic [31:0] s_addr, s_wdata;
  logic        s_we;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(input int imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    logic [31:0] v;
    v = imm;
    return {v[11:0], rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input int imm, input logic [4:0] rs2, input logic [4:0] rs1);
    logic [31:0] v;
    v = imm;
    return {v[11:5], rs2, rs1, 3'b010, v[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input int imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    logic [31:0] v;
    v = imm;
    return {v[12], v[10:5], rs2, rs1, f3, v[4:1], v[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input int imm, input logic [4:0] rd);
    logic [31:0] v;
    v = imm;
    return {v[20], v[10:1], v[11], v[19:12], rd, 7'b1101111};
  endfunction

  // One clock: drive the slave at the falling edge, apply completed writes just after the rising edge.
  task automatic tick();
    @(negedge clk);
    if (mem_req) begin
      if (pend) begin
        check("stall_addr", mem_addr, s_addr);
        check("stall_we", 32'(mem_we), 32'(s_we));
        if (s_we) check("stall_wdata", mem_wdata, s_wdata);
      end else begin
        pend = 1'b1;
        wl   = stall_mode ? int'($urandom_range(3, 0)) : 0;
      end
      s_addr    = mem_addr;
      s_we      = mem_we;
      s_wdata   = mem_wdata;
      mem_ready = !hold_ready && (wl == 0);
      if (wl > 0) wl--;
      mem_rdata = mem_ready ? mem[mem_addr[7:2]] : 32'hDEAD_BEEF;
    end else begin
      pend      = 1'b0;
      mem_ready = !stall_mode && !hold_ready;
      mem_rdata = 32'hDEAD_BEEF;
    end
    done        = mem_req && mem_ready;
    mem_rdata16 = p16[mem_addr16[3:2]];
    @(posedge clk);
    #1;
    if (done) begin
      pend = 1'b0;
      if (s_we) begin
        mem[s_addr[7:2]] = s_wdata;
        nwrites++;
      end else begin
        rlog.push_back(s_addr);
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic hold_reset();
    reset = 1'b0;
    ticks(2);
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
  endtask

  task automatic release_reset();
    rlog.delete();
    nwrites = 0;
    pend    = 1'b0;
    reset   = 1'b1;
    tick();
  endtask

  task automatic run_to_halt(input string tag, input int budget);
    for (int i = 0; i < budget && !halted; i++) tick();
    check(tag, 32'(halted), 32'd1);
  endtask

  logic [31:0] exp_log [9];

  initial begin
    reset       = 1'b1;
    mem_ready   = 1'b1;
    mem_ready16 = 1'b1;
    mem_rdata   = '0;
    mem_rdata16 = '0;
    stall_mode  = 1'b0;
    hold_ready  = 1'b0;
    pend        = 1'b0;
    wl          = 0;
    nwrites     = 0;
    p16[0] = enc_i(1, 5'd0, 3'b000, 5'd15, 7'b0010011);
    p16[1] = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd16);
    p16[2] = enc_i(0, 5'd0, 3'b000, 5'd0, 7'b0010011);
    p16[3] = enc_i(0, 5'd0, 3'b000, 5'd0, 7'b0010011);
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;

    // Reset values, asserted asynchronously before any clock edge
    #1 reset = 1'b0;
    #2;
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_instret", instret, 32'd0);

    // Zero-wait arithmetic/load/store program
    hold_reset();
    mem[0] = enc_i(5, 5'd0, 3'b000, 5'd1, 7'b0010011);
    mem[1] = enc_i(-3, 5'd0, 3'b000, 5'd2, 7'b0010011);
    mem[2] = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
    mem[3] = enc_s(8, 5'd3, 5'd0);
    mem[4] = enc_i(8, 5'd0, 3'b010, 5'd4, 7'b0000011);
    mem[5] = enc_s(12, 5'd4, 5'd0);
    mem[6] = 32'h0000_007F;
    check("rst_hold_req", 32'(mem_req), 32'd0);
    release_reset();
    check("first_fetch_req", 32'(mem_req), 32'd1);
    check("first_fetch_addr", mem_addr, 32'h0);
    check("first_fetch_we", 32'(mem_we), 32'd0);
    ticks(20);
    check("p1_instret_20", instret, 32'd4);
    ticks(1);
    check("p1_instret_21", instret, 32'd5);
    check("p1_mem8", mem[2], 32'd2);
    ticks(4);
    check("p1_instret_25", instret, 32'd6);
    check("p1_x4_stored", mem[3], 32'd2);
    ticks(1);
    check("p1_halt_early", 32'(halted), 32'd0);
    ticks(1);
    check("p1_halted", 32'(halted), 32'd1);
    check("p1_halt_req", 32'(mem_req), 32'd0);
    ticks(3);
    check("p1_halt_instret", instret, 32'd6);
    check("p1_nwrites", 32'(nwrites), 32'd2);

    // Same program with random wait states
    hold_reset();
    mem[0] = enc_i(5, 5'd0, 3'b000, 5'd1, 7'b0010011);
    mem[1] = enc_i(-3, 5'd0, 3'b000, 5'd2, 7'b0010011);
    mem[2] = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
    mem[3] = enc_s(8, 5'd3, 5'd0);
    mem[4] = enc_i(8, 5'd0, 3'b010, 5'd4, 7'b0000011);
    mem[5] = enc_s(12, 5'd4, 5'd0);
    mem[6] = 32'h0000_007F;
    stall_mode = 1'b1;
    release_reset();
    run_to_halt("p2_halt", 500);
    check("p2_instret", instret, 32'd6);
    check("p2_mem8", mem[2], 32'd2);
    check("p2_x4_stored", mem[3], 32'd2);
    check("p2_nwrites", 32'(nwrites), 32'd2);
    stall_mode = 1'b0;

    // Branches with x1 = -1, x2 = 1
    hold_reset();
    mem[0] = enc_i(-1, 5'd0, 3'b000, 5'd1, 7'b0010011);
    mem[1] = enc_i(1, 5'd0, 3'b000, 5'd2, 7'b0010011);
    mem[2] = enc_b(8, 5'd2, 5'd1, 3'b100);
    mem[3] = 32'h0000_007F;
    mem[4] = enc_b(8, 5'd2, 5'd1, 3'b101);
    mem[5] = enc_b(8, 5'd1, 5'd1, 3'b001);
    mem[6] = enc_b(-4, 5'd0, 5'd0, 3'b000);
    mem[7] = 32'h0000_007F;
    release_reset();
    ticks(26);
    check("br_instret", instret, 32'd8);
    ticks(4);
    check("br_not_halted", 32'(halted), 32'd0);
    check("br_log_len", 32'(rlog.size() >= 9), 32'd1);
    exp_log = '{32'h00, 32'h04, 32'h08, 32'h10, 32'h14, 32'h18, 32'h14, 32'h18, 32'h14};
    for (int i = 0; i < 9; i++)
      check($sformatf("br_fetch%0d", i), (i < rlog.size()) ? rlog[i] : 32'hFFFF_FFFF, exp_log[i]);

    // jal with link, and x0 staying zero
    hold_reset();
    mem[0]  = enc_j(32, 5'd0);
    mem[8]  = enc_j(12, 5'd5);
    mem[11] = enc_i(7, 5'd0, 3'b000, 5'd0, 7'b0010011);
    mem[12] = enc_s(32'h40, 5'd5, 5'd0);
    mem[13] = enc_s(32'h44, 5'd0, 5'd0);
    mem[14] = 32'h0000_007F;
    mem[17] = 32'hFFFF_FFFF;
    release_reset();
    run_to_halt("jal_halt", 100);
    check("jal_instret", instret, 32'd5);
    check("jal_link_x5", mem[16], 32'h24);
    check("jal_x0_zero", mem[17], 32'h0);
    exp_log[0:5] = '{32'h00, 32'h20, 32'h2C, 32'h30, 32'h34, 32'h38};
    for (int i = 0; i < 6; i++)
      check($sformatf("jal_fetch%0d", i), (i < rlog.size()) ? rlog[i] : 32'hFFFF_FFFF, exp_log[i]);

    // Misaligned load traps without any data access
    hold_reset();
    mem[0] = enc_i(6, 5'd0, 3'b000, 5'd1, 7'b0010011);
    mem[1] = enc_i(0, 5'd1, 3'b010, 5'd2, 7'b0000011);
    mem[2] = enc_s(0, 5'd1, 5'd0);
    release_reset();
    run_to_halt("lw_mis_halt", 100);
    ticks(2);
    check("lw_mis_instret", instret, 32'd1);
    check("lw_mis_req", 32'(mem_req), 32'd0);
    check("lw_mis_reads", 32'(rlog.size()), 32'd2);
    check("lw_mis_nwrites", 32'(nwrites), 32'd0);
    check("rv32e_halted", 32'(halted16), 32'd1);
    check("rv32e_instret", instret16, 32'd1);
    check("rv32e_req", 32'(mem_req16), 32'd0);

    // Reset while a store is stalled
    hold_reset();
    mem[0] = enc_i(9, 5'd0, 3'b000, 5'd1, 7'b0010011);
    mem[1] = enc_s(32'h10, 5'd1, 5'd0);
    mem[2] = 32'h0000_007F;
    mem[4] = 32'h5555_5555;
    release_reset();
    ticks(7);
    check("sw_req", 32'(mem_req), 32'd1);
    check("sw_we", 32'(mem_we), 32'd1);
    check("sw_addr", mem_addr, 32'h10);
    check("sw_wdata", mem_wdata, 32'd9);
    hold_ready = 1'b1;
    ticks(2);
    #2 reset = 1'b0;
    #1;
    check("async_drop_req", 32'(mem_req), 32'd0);
    check("async_drop_we", 32'(mem_we), 32'd0);
    hold_ready = 1'b0;
    ticks(2);
    check("abandoned_mem", mem[4], 32'h5555_5555);
    check("abandoned_nwrites", 32'(nwrites), 32'd0);
    check("abandoned_instret", instret, 32'd0);
    release_reset();
    check("restart_req", 32'(mem_req), 32'd1);
    check("restart_addr", mem_addr, 32'h0);
    check("restart_we", 32'(mem_we), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
